// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the pipelined RV32I/RV64I core.
//   imm_type_e  - immediate format code carried with each decoded bundle.
//                 Codes 0-4 match the single-cycle core's encoding.
//   OP_*        - 7-bit major opcodes (inst[6:0]).
package core_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_NONE  = 3'd2,
        IMM_B     = 3'd3,
        IMM_J     = 3'd4,
        IMM_U     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZCSR  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: purely combinational immediate decoder.
//   inst     in  32    instruction word
//   imm      out XLEN  sign/zero-extended immediate
//   imm_type out 3     imm_type_e code derived from opcode/funct3
//   illegal  out 1     opcode not recognised (includes inst[1:0] != 2'b11)
module imm_decode_comb
    import core_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ILLEGAL_ZERO_IMM = 1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    // Every format is built at 64 bits and then cut to XLEN, so the
    // RV64 sign extension falls out naturally without zero-width repeats.
    logic [63:0] imm_i64;
    logic [63:0] imm_s64;
    logic [63:0] imm_b64;
    logic [63:0] imm_j64;
    logic [63:0] imm_u64;
    logic [63:0] imm_shamt64;
    logic [63:0] imm_zcsr64;
    logic [63:0] imm_sel64;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    assign imm_i64     = {{52{inst[31]}}, inst[31:20]};
    assign imm_s64     = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b64     = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j64     = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u64     = {{32{inst[31]}}, inst[31:12], 12'b0};
    // RV64 shifts use a 6-bit shamt; RV32 only the low 5 bits.
    assign imm_shamt64 = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
    assign imm_zcsr64  = {59'b0, inst[19:15]};

    always_comb begin
        imm_type  = IMM_NONE;
        illegal   = 1'b0;
        imm_sel64 = 64'b0;
        case (opcode)
            OP_LOAD, OP_FENCE, OP_JALR: begin
                imm_type  = IMM_I;
                imm_sel64 = imm_i64;
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_type  = IMM_SHAMT;
                    imm_sel64 = imm_shamt64;
                end else begin
                    imm_type  = IMM_I;
                    imm_sel64 = imm_i64;
                end
            end
            OP_STORE: begin
                imm_type  = IMM_S;
                imm_sel64 = imm_s64;
            end
            OP_BRANCH: begin
                imm_type  = IMM_B;
                imm_sel64 = imm_b64;
            end
            OP_JAL: begin
                imm_type  = IMM_J;
                imm_sel64 = imm_j64;
            end
            OP_LUI, OP_AUIPC: begin
                imm_type  = IMM_U;
                imm_sel64 = imm_u64;
            end
            OP_OP: begin
                imm_type  = IMM_NONE;
                imm_sel64 = 64'b0;
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    imm_type  = IMM_ZCSR;
                    imm_sel64 = imm_zcsr64;
                end else begin
                    imm_type  = IMM_I;
                    imm_sel64 = imm_i64;
                end
            end
            default: begin
                // Every legal opcode ends in 2'b11, so this arm also covers
                // compressed/reserved encodings.
                imm_type  = IMM_NONE;
                illegal   = 1'b1;
                imm_sel64 = (ILLEGAL_ZERO_IMM != 0) ? 64'b0 : imm_i64;
            end
        endcase
    end

    assign imm = imm_sel64[XLEN-1:0];

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate-decode stage with a 2-entry skid
// buffer (main + skid) and valid/ready handshake.
//   clk, rst (async active-low), flush (sync)
//   in_valid/in_ready/in_inst/in_pc           upstream handshake + bundle
//   out_valid/out_ready                       downstream handshake
//   out_inst/out_pc/out_imm/out_imm_type/out_illegal  registered bundle
module imm_decode_stage
    import core_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ILLEGAL_ZERO_IMM = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;

    imm_decode_comb #(
        .XLEN             (XLEN),
        .ILLEGAL_ZERO_IMM (ILLEGAL_ZERO_IMM)
    ) u_dec (
        .inst     (in_inst),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    logic            main_valid_reg;
    logic [31:0]     main_inst_reg;
    logic [XLEN-1:0] main_pc_reg;
    logic [XLEN-1:0] main_imm_reg;
    imm_type_e       main_type_reg;
    logic            main_illegal_reg;

    logic            skid_valid_reg;
    logic [31:0]     skid_inst_reg;
    logic [XLEN-1:0] skid_pc_reg;
    logic [XLEN-1:0] skid_imm_reg;
    imm_type_e       skid_type_reg;
    logic            skid_illegal_reg;

    logic accept;

    // in_ready comes straight from a flop, so out_ready never reaches it
    // combinationally.
    assign in_ready = !skid_valid_reg;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_reg   <= 1'b0;
            main_inst_reg    <= '0;
            main_pc_reg      <= '0;
            main_imm_reg     <= '0;
            main_type_reg    <= IMM_I;
            main_illegal_reg <= 1'b0;
            skid_valid_reg   <= 1'b0;
            skid_inst_reg    <= '0;
            skid_pc_reg      <= '0;
            skid_imm_reg     <= '0;
            skid_type_reg    <= IMM_I;
            skid_illegal_reg <= 1'b0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (main_valid_reg && !out_ready) begin
            // Main is held: park a new bundle in skid.
            if (accept) begin
                skid_valid_reg   <= 1'b1;
                skid_inst_reg    <= in_inst;
                skid_pc_reg      <= in_pc;
                skid_imm_reg     <= dec_imm;
                skid_type_reg    <= dec_type;
                skid_illegal_reg <= dec_illegal;
            end
        end else if (skid_valid_reg) begin
            // Skid can only be full while main is valid, so here main is
            // delivering; in_ready is low so no accept competes.
            main_valid_reg   <= 1'b1;
            main_inst_reg    <= skid_inst_reg;
            main_pc_reg      <= skid_pc_reg;
            main_imm_reg     <= skid_imm_reg;
            main_type_reg    <= skid_type_reg;
            main_illegal_reg <= skid_illegal_reg;
            skid_valid_reg   <= 1'b0;
        end else begin
            // Main empty or delivering with skid empty.
            main_valid_reg <= accept;
            if (accept) begin
                main_inst_reg    <= in_inst;
                main_pc_reg      <= in_pc;
                main_imm_reg     <= dec_imm;
                main_type_reg    <= dec_type;
                main_illegal_reg <= dec_illegal;
            end
        end
    end

    assign out_valid    = main_valid_reg;
    assign out_inst     = main_inst_reg;
    assign out_pc       = main_pc_reg;
    assign out_imm      = main_imm_reg;
    assign out_imm_type = main_type_reg;
    assign out_illegal  = main_illegal_reg;

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered immediate-decode stage for the pipelined RV32I/RV64I core.
- Derives the immediate type from the instruction's own opcode/funct3, so control no longer supplies an imm_type input.
- Generates the XLEN-wide sign- or zero-extended immediate, including U, shamt and CSR-zimm forms.
- Carries inst and pc forward through a 2-entry skid buffer with a valid/ready handshake and flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ILLEGAL_ZERO_IMM, 1, when 1 an illegal instruction outputs imm = 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_inst  out  32  registered instruction.
- out_pc  out  XLEN  registered PC.
- out_imm  out  XLEN  extended immediate.
- out_imm_type  out  3  imm_type_e code.
- out_illegal  out  1  unrecognised opcode, or inst[1:0] != 2'b11.

Behaviour:
- Reset (rst = 0, async): both entries invalid, all out_* = 0, in_ready = 1.
- Accept condition: in_valid && in_ready. Deliver condition: out_valid && out_ready.
- Latency: exactly 1 cycle from acceptance to out_valid when the stage is empty.
- Storage: main register drives out_*; skid register catches an accept made while main is held.
- in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
- Per-edge state rules:
  - main empty, or main delivering with skid empty: an accepted bundle loads main.
  - main held and not delivering: an accepted bundle loads skid; in_ready drops on the next cycle.
  - main delivering with skid full: skid moves to main; skid is cleared; a simultaneous accept is impossible because in_ready = 0.
- Ordering is strictly FIFO. Bundles are never dropped or duplicated.
- Output stability: while out_valid && !out_ready, every out_* field holds stable.
- Flush: on the next edge both valid bits clear and any simultaneous accept is discarded. out_valid = 0 and in_ready = 1 on the following cycle. Flush has priority over all other events.
- Reset mid-transfer: immediate clear of all state; no partial bundle survives.
- Decode is combinational on in_inst; the result is registered with the bundle.
- Decode map (by opcode; all sign extensions use inst[31] up to XLEN):
  - 0000011, 0001111, 1100111: I, {inst[31:20]}.
  - 0010011 with funct3 001/101: SHAMT, zero-extended inst[24:20] (XLEN 32) or inst[25:20] (XLEN 64).
  - 0010011 other funct3: I.
  - 0100011: S, {inst[31:25], inst[11:7]}.
  - 1100011: B, {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 1101111: J, {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 0110111 / 0010111: U, {inst[31:12], 12'b0}, sign-extended to XLEN.
  - 0110011: NONE, imm 0.
  - 1110011 with funct3[2] = 1: ZCSR, zero-extended inst[19:15].
  - 1110011 with funct3[2] = 0: I.
  - Any other opcode: NONE with illegal = 1; imm = 0 if ILLEGAL_ZERO_IMM.
- Width rule: every immediate is produced at XLEN bits. No truncation is permitted for XLEN = 64.

Decomposition:
- Shared package core_pkg holds imm_type_e and the opcode constants:
  - imm_type_e: IMM_I = 0, IMM_S = 1, IMM_NONE = 2, IMM_B = 3, IMM_J = 4, IMM_U = 5, IMM_SHAMT = 6, IMM_ZCSR = 7. Codes 0–4 keep the single-cycle core's existing encoding.
  - Opcode constants: OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_SYSTEM, OP_FENCE.
- One sub-module: imm_decode_comb, a purely combinational decoder (inst → imm, imm_type, illegal), parametrised by XLEN.
- The top level contains only the skid-buffer control and registers.

Test Plan:
- XLEN = 32, single transfers with out_ready = 1 (each bundle appears 1 cycle after acceptance):
  - 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, type I.
  - 0xFE112E23 (sw -4) → imm 0xFFFFFFFC, type S.
  - 0x123452B7 (lui) → imm 0x12345000, type U.
  - 0xFF9FF06F (jal -8) → imm 0xFFFFFFF8, type J.
- Illegal and NONE cases:
  - 0x00000000 → illegal = 1, imm 0, type NONE.
  - 0x002081B3 (add) → illegal = 0, type NONE.
- Backpressure: in_valid held high with 4 distinct instructions, out_ready low for 3 cycles → exactly 2 accepted; in_ready = 0 from the cycle after the skid fills; out_* stable throughout. After release, all 4 delivered in order, none lost.
- Flush with main and skid both full and in_valid = 1 → next cycle out_valid = 0, in_ready = 1; the in-flight instruction is never delivered.
- rst asserted mid-stall → out_valid and all out_* = 0 immediately (asynchronously), in_ready = 1. After release, the first new instruction is delivered with 1-cycle latency.
- XLEN = 64:
  - 0x80000537 (lui 0x80000) → imm 0xFFFFFFFF80000000.
  - 0x03F09093 (slli 63) → type SHAMT, imm 63.
